mdu_iter_div: RTL and testbench

Iterative radix-2 restoring divider that produces the quotient and remainder the MDU commits to Hi/Lo for `div`/`divu`. It replaces the single-cycle `/` and `%` operators with a fixed-latency sequential datapath. It sits in the E stage directly upstream of the Hi/Lo registers and is driven from the same operand buses. Its busy output feeds the stall logic.

---
 rtl/mdu_iter_div_pkg.sv | 14 +
 rtl/mdu_div_step.sv | 24 ++
 rtl/mdu_iter_div.sv | 133 +++++++++++++
 tb/tb_mdu_iter_div.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_div_pkg.sv
// Shared definitions for the iterative MDU divider: FSM encodings and the
// MDU operation codes that the MDU decodes into start/is_signed.
package mdu_iter_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  localparam logic [3:0] MDU_OP_DIV  = 4'h4;
  localparam logic [3:0] MDU_OP_DIVU = 4'h5;

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Trial subtraction in WIDTH+1 bits; bit WIDTH is the borrow (trial < 0).
  always_comb begin
    w_shift = {i_rem, i_q[WIDTH-1]};
    w_trial = w_shift - {1'b0, i_divisor};
    o_q     = {i_q[WIDTH-2:0], ~w_trial[WIDTH]};
    o_rem   = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter_div.sv
// Iterative restoring divider for div/divu. Fixed WIDTH+1 cycle latency;
// results land in registered outputs held until the next done pulse.
module mdu_iter_div
  import mdu_iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd_orig;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dzo;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Operand magnitudes; unsigned operands pass through untouched.
  always_comb begin
    w_dvd_neg = is_signed & dividend[WIDTH-1];
    w_dvs_neg = is_signed & divisor[WIDTH-1];
    w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    w_dvs_mag = w_dvs_neg ? -divisor : divisor;
  end

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_q       (r_q),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_q       (w_q_nxt)
  );

  // Divider FSM: latch operands, iterate WIDTH times, sign-fix and publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= DIV_IDLE;
      r_rem      <= '0;
      r_q        <= '0;
      r_dvs      <= '0;
      r_dvd_orig <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_dz       <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_remo     <= '0;
      r_dzo      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            // r_q starts as the dividend magnitude and is shifted out MSB first.
            r_q        <= w_dvd_mag;
            r_dvs      <= w_dvs_mag;
            r_rem      <= '0;
            r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg    <= w_dvd_neg;
            r_dz       <= (divisor == '0);
            r_dvd_orig <= dividend;
            r_cnt      <= CW'(WIDTH);
            r_busy     <= 1'b1;
            r_state    <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          if (r_dz) begin
            r_quot <= '1;
            r_remo <= r_dvd_orig;
          end else begin
            r_quot <= r_q_neg ? -r_q : r_q;
            r_remo <= r_r_neg ? -r_rem : r_rem;
          end
          r_dzo   <= r_dz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign div_zero  = r_dzo;

endmodule

// File: tb/tb_mdu_iter_div.sv
// Self-checking bench for mdu_iter_div: behavioural divide model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_mdu_iter_div;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iter_div #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of div/divu: {div_zero, quotient, remainder}.
  function automatic logic [2*W:0] model_div(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, sq, sr;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (sgn) begin
      if (a == SMIN && b == '1) return {1'b0, SMIN, {W{1'b0}}};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, W'(sq), W'(sr)};
    end
    return {1'b0, a / b, a % b};
  endfunction

  // Model: a division occupies W+1 cycles; results appear as it finishes.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_dz, p_dz;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_q  <= p_q;
        m_r  <= p_r;
        m_dz <= p_dz;
      end
      if (m_left > 0) m_left <= m_left - 1;
      else if (start) begin
        m_left <= W + 1;
        {p_dz, p_q, p_r} <= model_div(is_signed, dividend, divisor);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", W'(busy), W'(m_left != 0));
    check("done", W'(done), W'(m_done));
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_zero", W'(div_zero), W'(m_dz));
  end

  // Issue one division (caller is just after an edge) and check literals.
  task automatic do_div(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz);
    int lat;
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no done within %0d cycles, required 33", name, lat);
    end else begin
      check({name, " latency"}, W'(lat), W'(W + 1));
      check({name, " quotient"}, quotient, eq);
      check({name, " remainder"}, remainder, er);
      check({name, " div_zero"}, W'(div_zero), W'(edz));
      check({name, " busy@done"}, W'(busy), '0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset quotient", quotient, '0);
    check("reset remainder", remainder, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(posedge clk);
    #1;
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_div("divu max/big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0);
    do_div("div 5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    do_div("divu 9/0", 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1);
    do_div("div -8/-3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE, 1'b0);

    // start re-asserted mid-division must be ignored
    @(posedge clk);
    #1;
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    check("ignored start quotient", quotient, 32'd111);
    check("ignored start remainder", remainder, 32'd1);
    // start in the done cycle is accepted (do_div checks latency 33)
    do_div("back-to-back 20/3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0);

    // asynchronous reset mid-iteration
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'hFFFF_FFFF;
    divisor   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async reset busy", W'(busy), '0);
    check("async reset done", W'(done), '0);
    check("async reset quotient", quotient, '0);
    check("async reset remainder", remainder, '0);
    check("async reset div_zero", W'(div_zero), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_div("after reset 1000/-7", 1'b1, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 32'd6, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
